// File: rtl/t_updown_counter.sv
// Synchronous up/down counter built from per-bit toggle cells.
// Supports parallel load, a combinational terminal count and a registered wrap pulse.
module t_updown_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_next;
  logic             at_end;

  // Ripple prefix of "all lower bits are 1 / are 0", driving each bit's toggle enable
  always_comb begin
    ones_below     = '0;
    zeros_below    = '0;
    ones_below[0]  = 1'b1;
    zeros_below[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      ones_below[i]  = ones_below[i-1] & q[i-1];
      zeros_below[i] = zeros_below[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    t = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t[i] = en & (up ? ones_below[i] : zeros_below[i]);
    end
  end

  // Terminal count: the next enabled step in the current direction wraps
  always_comb begin
    at_end = up ? (ones_below[MSB] & q[MSB]) : (zeros_below[MSB] & ~q[MSB]);
    tc     = en & at_end & ~load;
  end

  always_comb begin
    q_next = load ? d : (q ^ t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= tc;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_t_updown_counter.sv
// Directed, table-driven checks for t_updown_counter at WIDTH=4,
// plus hand-written sequences around asynchronous reset.
module tb_t_updown_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         tc;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;    // expected q after the edge
    logic         ovf;  // expected ovf after the edge
    logic         tc;   // expected tc before the edge
    string        name;
  } vec_t;

  vec_t vecs[$];

  t_updown_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .q_bar (q_bar),
    .tc    (tc),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u, input logic l, input logic [W-1:0] dv,
                     input logic [W-1:0] eq, input logic eo, input logic et, input string nm);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.d = dv;
    v.q = eq; v.ovf = eo; v.tc = et; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;

    // 17 up-count edges from reset: wrap after 15
    for (int k = 0; k < 17; k++) begin
      add(1'b1, 1'b1, 1'b0, 4'h0, W'((k + 1) % 16), (k % 16) == 15, (k % 16) == 15, "up_run");
    end
    add(1'b1, 1'b1, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0, "load3");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, "down_2");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, "down_1");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "down_0");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, "down_wrap");
    add(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, "hold_clr_ovf");
    add(1'b1, 1'b1, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0, "load_over_tc");
    add(1'b0, 1'b1, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, "load7");
    add(1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, "dir_up");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0, 1'b0, "dir_dn");
    add(1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, "dir_up2");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0, 1'b0, "dir_dn2");
    for (int k = 0; k < 10; k++) begin
      add(1'b0, k[0], 1'b0, W'(k), 4'h7, 1'b0, 1'b0, "en_off");
    end
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "load0");
    add(1'b1, 1'b0, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0, "load_at_zero_down");
    add(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, "loadF");
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, "down_from_max");

    // Reset state, checked between edges
    #2;
    chk("rst_q", q, 4'h0);
    chk("rst_q_bar", q_bar, 4'hF);
    chk("rst_ovf", W'(ovf), 4'h0);
    chk("rst_tc", W'(tc), 4'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en; up = vecs[i].up; load = vecs[i].load; d = vecs[i].d;
      #1;
      chk($sformatf("%s[%0d] tc", vecs[i].name, i), W'(tc), W'(vecs[i].tc));
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d] q", vecs[i].name, i), q, vecs[i].q);
      chk($sformatf("%s[%0d] q_bar", vecs[i].name, i), q_bar, ~vecs[i].q);
      chk($sformatf("%s[%0d] ovf", vecs[i].name, i), W'(ovf), W'(vecs[i].ovf));
    end

    // Async reset between edges while q=0xC, then resume counting from 1
    @(negedge clk);
    en = 1'b0; load = 1'b1; d = 4'hC;
    @(posedge clk); #1;
    chk("seqC_load", q, 4'hC);
    #2;
    load = 1'b0; en = 1'b1; up = 1'b0; rst = 1'b1;
    #1;
    chk("seqC_rst_q", q, 4'h0);
    chk("seqC_rst_q_bar", q_bar, 4'hF);
    chk("seqC_rst_ovf", W'(ovf), 4'h0);
    chk("seqC_rst_tc_down", W'(tc), 4'h1);
    @(posedge clk); #1;
    chk("seqC_rst_hold_q", q, 4'h0);
    chk("seqC_rst_hold_ovf", W'(ovf), 4'h0);
    @(negedge clk);
    rst = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    chk("seqC_resume_q", q, 4'h1);

    // Reset right after a wrap edge kills the ovf pulse
    @(negedge clk);
    load = 1'b1; d = 4'hF; en = 1'b1; up = 1'b1;
    @(posedge clk); #1;
    chk("wrap_loadF", q, 4'hF);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #1;
    chk("wrap_q", q, 4'h0);
    chk("wrap_ovf", W'(ovf), 4'h1);
    rst = 1'b1;
    #1;
    chk("wrap_rst_ovf", W'(ovf), 4'h0);
    chk("wrap_rst_q", q, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted on a pending wrap cycle discards step and pulse
    load = 1'b1; d = 4'hF;
    @(posedge clk); #1;
    chk("pend_loadF", q, 4'hF);
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("pend_tc", W'(tc), 4'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("pend_q", q, 4'h0);
    chk("pend_ovf", W'(ovf), 4'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("pend_idle_q", q, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
